// File: rtl/micro_ondas_pkg.sv
// Shared types and constants for the micro_ondas keypad/timer datapath.
// Digits are carried as raw BCD throughout; there is no binary conversion.
package micro_ondas_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t MAX_DIGIT    = 4'd9;
   localparam bcd_t MAX_SEC_TENS = 4'd5;

   typedef enum logic [1:0] {
      DB_RELEASED,
      DB_PRESS_WAIT,
      DB_HELD,
      DB_RELEASE_WAIT
   } db_state_t;

endpackage

// File: rtl/strobe_debounce.sv
// Debounces the active-low keypad strobe and emits one accept pulse per press.
// A level must persist DEBOUNCE_CYCLES samples before it is believed.
module strobe_debounce
   import micro_ondas_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic clearn,
   input  logic loadn,
   output logic accept
);

   localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES);

   db_state_t  state, state_next;
   logic [7:0] cnt, cnt_next;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state <= DB_RELEASED;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         DB_RELEASED: begin
            if (!loadn) begin
               state_next = DB_PRESS_WAIT;
               cnt_next   = 8'd1;
            end
         end
         DB_PRESS_WAIT: begin
            if (cnt >= LIMIT)  state_next = DB_HELD;
            else if (loadn)    state_next = DB_RELEASED;
            else               cnt_next   = cnt + 8'd1;
         end
         DB_HELD: begin
            if (loadn) begin
               state_next = DB_RELEASE_WAIT;
               cnt_next   = 8'd1;
            end
         end
         DB_RELEASE_WAIT: begin
            if (cnt >= LIMIT)  state_next = DB_RELEASED;
            else if (!loadn)   state_next = DB_HELD;
            else               cnt_next   = cnt + 8'd1;
         end
         default: state_next = DB_RELEASED;
      endcase
   end

   // The press is believed for exactly the one cycle spent leaving PRESS_WAIT.
   always_comb begin
      accept = (state == DB_PRESS_WAIT) && (cnt >= LIMIT);
   end

endmodule

// File: rtl/keypad_entry_rx.sv
// Keypad digit receiver: debounces presses, shifts digits into an M:SS preset
// and offers it to the timer over a valid/ready handshake.
module keypad_entry_rx
   import micro_ondas_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       loadn,
   input  logic [3:0] bcd,
   input  logic       mag_on,
   input  logic       entry_clr,
   input  logic       preset_ready,
   output logic       preset_valid,
   output logic [3:0] preset_mins,
   output logic [3:0] preset_sec_tens,
   output logic [3:0] preset_sec_ones,
   output logic [1:0] digit_count,
   output logic       err_digit,
   output logic       err_range
);

   logic accept;
   logic take;
   logic digit_ok;
   logic transfer;

   strobe_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clock  (clock),
      .clearn (clearn),
      .loadn  (loadn),
      .accept (accept)
   );

   always_comb begin
      take         = accept && !mag_on;
      digit_ok     = (bcd <= MAX_DIGIT);
      preset_valid = (digit_count != 2'd0) && (preset_sec_tens <= MAX_SEC_TENS) && !mag_on;
      err_range    = (digit_count != 2'd0) && (preset_sec_tens > MAX_SEC_TENS);
      transfer     = preset_valid && preset_ready;
   end

   // Cancel beats everything; a digit landing on a transfer starts the next preset.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         preset_mins     <= '0;
         preset_sec_tens <= '0;
         preset_sec_ones <= '0;
         digit_count     <= '0;
         err_digit       <= 1'b0;
      end else begin
         err_digit <= take && !digit_ok && !entry_clr;
         if (entry_clr) begin
            preset_mins     <= '0;
            preset_sec_tens <= '0;
            preset_sec_ones <= '0;
            digit_count     <= '0;
         end else if (take && digit_ok) begin
            if (transfer) begin
               preset_mins     <= '0;
               preset_sec_tens <= '0;
               preset_sec_ones <= bcd;
               digit_count     <= 2'd1;
            end else begin
               preset_mins     <= preset_sec_tens;
               preset_sec_tens <= preset_sec_ones;
               preset_sec_ones <= bcd;
               digit_count     <= (digit_count == 2'd3) ? 2'd3 : digit_count + 2'd1;
            end
         end else if (transfer) begin
            preset_mins     <= '0;
            preset_sec_tens <= '0;
            preset_sec_ones <= '0;
            digit_count     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry_rx.sv
// Randomised scoreboard bench for keypad_entry_rx against a queue-of-digits
// reference model with a run-length view of the debounced strobe.
module tb_keypad_entry_rx;

   localparam int N = 4;

   logic       clock = 1'b0;
   logic       clearn = 1'b0;
   logic       loadn = 1'b1;
   logic [3:0] bcd = 4'd0;
   logic       mag_on = 1'b0;
   logic       entry_clr = 1'b0;
   logic       preset_ready = 1'b0;
   logic       preset_valid;
   logic [3:0] preset_mins, preset_sec_tens, preset_sec_ones;
   logic [1:0] digit_count;
   logic       err_digit, err_range;

   keypad_entry_rx #(.DEBOUNCE_CYCLES(N)) dut (
      .clock           (clock),
      .clearn          (clearn),
      .loadn           (loadn),
      .bcd             (bcd),
      .mag_on          (mag_on),
      .entry_clr       (entry_clr),
      .preset_ready    (preset_ready),
      .preset_valid    (preset_valid),
      .preset_mins     (preset_mins),
      .preset_sec_tens (preset_sec_tens),
      .preset_sec_ones (preset_sec_ones),
      .digit_count     (digit_count),
      .err_digit       (err_digit),
      .err_range       (err_range)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] mins;
      logic [3:0] tens;
      logic [3:0] ones;
      logic [1:0] count;
      logic       valid;
      logic       err_digit;
      logic       err_range;
   } snap_t;

   snap_t       snap_q[$];
   logic [11:0] xfer_q[$];
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entered digits (last three), debounced level and run length.
   int q[$];
   bit m_pressed, m_skip, m_pend, m_err;
   int m_run;

   function automatic int mdig(int k);
      return (q.size() > k) ? q[q.size() - 1 - k] : 0;
   endfunction

   function automatic bit m_valid(bit mag);
      return (q.size() > 0) && (mdig(1) <= 5) && !mag;
   endfunction

   function automatic snap_t m_snap(bit mag);
      snap_t s;
      s.mins      = 4'(mdig(2));
      s.tens      = 4'(mdig(1));
      s.ones      = 4'(mdig(0));
      s.count     = 2'(q.size());
      s.valid     = m_valid(mag);
      s.err_digit = m_err;
      s.err_range = (q.size() > 0) && (mdig(1) > 5);
      return s;
   endfunction

   task automatic m_reset();
      q.delete();
      m_pressed = 0; m_skip = 0; m_pend = 0; m_err = 0; m_run = 0;
   endtask

   task automatic m_edge(bit ln, int b, bit mag, bit clr, bit rdy);
      bit e = 0;
      bit xf = m_valid(mag) && rdy;
      if (clr) q.delete();
      else begin
         if (xf) q.delete();
         if (m_pend && !mag) begin
            if (b <= 9) begin
               q.push_back(b);
               if (q.size() > 3) void'(q.pop_front());
            end else e = 1;
         end
      end
      m_err  = e;
      m_pend = 0;
      // A recognised level change costs one edge before counting restarts.
      if (m_skip) begin
         m_skip = 0;
         m_run  = 0;
      end else begin
         if (ln == m_pressed) m_run++;
         else m_run = 0;
         if (m_run == N) begin
            if (!m_pressed) m_pend = 1;
            m_pressed = !m_pressed;
            m_skip    = 1;
            m_run     = 0;
         end
      end
   endtask

   task automatic cyc(bit ln, logic [3:0] b, bit mag, bit clr, bit rdy);
      loadn = ln; bcd = b; mag_on = mag; entry_clr = clr; preset_ready = rdy;
      snap_q.push_back(m_snap(mag));
      if (m_valid(mag) && rdy) xfer_q.push_back({4'(mdig(2)), 4'(mdig(1)), 4'(mdig(0))});
      @(posedge clock);
      #1;
      m_edge(ln, int'(b), mag, clr, rdy);
   endtask

   task automatic do_reset();
      clearn = 1'b0;
      m_reset();
      #1;
      check("reset_now", {preset_mins, preset_sec_tens, preset_sec_ones, digit_count, preset_valid, err_digit},
            {4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0});
      snap_q.push_back(m_snap(mag_on));
      @(posedge clock);
      #1;
      clearn = 1'b1;
   endtask

   task automatic expect_now(string name, logic [3:0] mi, logic [3:0] te, logic [3:0] on,
                             logic [1:0] cn, logic va, logic er);
      check(name, {preset_mins, preset_sec_tens, preset_sec_ones, digit_count, preset_valid, err_range},
            {mi, te, on, cn, va, er});
   endtask

   bit mag_v = 0;
   bit rand_rdy = 0;

   task automatic press(logic [3:0] b, int lo, int hi, int rdy_at = -1, int clr_at = -1);
      for (int i = 0; i < lo; i++)
         cyc(1'b0, b, mag_v, i == clr_at, (i == rdy_at) || (rand_rdy && $urandom_range(0, 7) == 0));
      for (int i = 0; i < hi; i++)
         cyc(1'b1, 4'($urandom_range(0, 15)), mag_v, 1'b0, rand_rdy && $urandom_range(0, 7) == 0);
   endtask

   // Monitor: pops one expected snapshot per cycle and one preset per transfer.
   always @(negedge clock) begin
      snap_t exp_s;
      if (snap_q.size() > 0) begin
         exp_s = snap_q.pop_front();
         check("state", {15'd0, preset_mins, preset_sec_tens, preset_sec_ones, digit_count,
                         preset_valid, err_digit, err_range}, {15'd0, exp_s});
      end
      if (clearn && preset_valid && preset_ready) begin
         if (xfer_q.size() == 0) check("unexpected_xfer", 32'd1, 32'd0);
         else check("xfer", {preset_mins, preset_sec_tens, preset_sec_ones}, xfer_q.pop_front());
      end
   end

   initial begin
      m_reset();
      repeat (2) @(posedge clock);
      #1;
      do_reset();

      press(4'd3, 10, 8);
      expect_now("first_digit", 0, 0, 3, 1, 1, 0);

      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      press(4'd1, 6, 6); press(4'd3, 6, 6); press(4'd0, 6, 6);
      expect_now("three_digits", 1, 3, 0, 3, 1, 0);
      press(4'd5, 6, 6);
      expect_now("fourth_digit", 3, 0, 5, 3, 1, 0);

      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      press(4'd9, 6, 6); press(4'd0, 6, 6);
      expect_now("range_err", 0, 9, 0, 2, 0, 1);
      press(4'd0, 6, 6);
      expect_now("nine_00", 9, 0, 0, 3, 1, 0);

      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      repeat (3) press(4'd7, 3, 3);
      press(4'd8, 6, 1); press(4'd8, 6, 6);
      expect_now("glitch", 0, 0, 8, 1, 1, 0);
      press(4'd12, 6, 6);
      expect_now("bad_digit", 0, 0, 8, 1, 1, 0);

      cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      press(4'd1, 6, 6); press(4'd2, 6, 6); press(4'd0, 6, 6);
      cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      expect_now("xfer_clear", 0, 0, 0, 0, 0, 0);
      press(4'd1, 6, 6); press(4'd2, 6, 6);
      press(4'd4, 6, 6, 4);
      expect_now("xfer_accept", 0, 0, 4, 1, 1, 0);

      mag_v = 1;
      press(4'd7, 6, 6);
      expect_now("mag_lock", 0, 0, 4, 1, 0, 0);
      mag_v = 0;

      press(4'd6, 6, 6, -1, 4);
      expect_now("clr_accept", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 6; i++) cyc(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
      do_reset();
      press(4'd2, 6, 6);
      expect_now("reset_held", 0, 0, 2, 1, 1, 0);

      rand_rdy = 1;
      for (int k = 0; k < 300; k++) begin
         mag_v = ($urandom_range(0, 9) == 0);
         press(4'($urandom_range(0, 11)), $urandom_range(1, 8), $urandom_range(1, 8), -1,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1);
      end
      mag_v = 0;
      cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

      @(negedge clock);
      #1;
      check("snap_drain", 32'(snap_q.size()), 32'd0);
      check("xfer_drain", 32'(xfer_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
